// File: rtl/tlb_refill_ctrl_pkg.sv
// rtl/tlb_refill_ctrl_pkg.sv - refill FSM state type and line offset helper
package tlb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    LAST,
    DONE
  } refill_state_t;

  // Word-offset bits inside a line; also the width of the beat counter.
  function automatic int offset_len(input int bank_num);
    return $clog2(bank_num);
  endfunction

endpackage

// File: rtl/tlb_refill_ctrl_if.sv
// rtl/tlb_refill_ctrl_if.sv - single-outstanding memory read request/response channel
interface tlb_refill_ctrl_if #(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64
);
  logic                  mem_req_valid;
  logic                  mem_req_ready;
  logic [ADDR_WIDTH-1:0] mem_req_addr;
  logic                  mem_resp_valid;
  logic [DATA_WIDTH-1:0] mem_resp_data;

  modport master (
    output mem_req_valid,
    output mem_req_addr,
    input  mem_req_ready,
    input  mem_resp_valid,
    input  mem_resp_data
  );

  modport slave (
    input  mem_req_valid,
    input  mem_req_addr,
    output mem_req_ready,
    output mem_resp_valid,
    output mem_resp_data
  );
endinterface

// File: rtl/tlb_refill_ctrl.sv
// rtl/tlb_refill_ctrl.sv - line refill engine: fetches BANK_NUM words per miss and writes them into the bank
module tlb_refill_ctrl
  import tlb_pkg::*;
#(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64,
  parameter int BANK_NUM   = 4
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  miss_cache,
  input  logic [ADDR_WIDTH-1:0] addr_cache,
  input  logic                  set_cache,
  output logic                  busy_rd,
  output logic [ADDR_WIDTH-1:0] addr_rd,
  output logic [DATA_WIDTH-1:0] data_rd,
  output logic                  wen_rd,
  output logic                  set_rd,
  output logic                  finish_rd,
  tlb_refill_ctrl_if.master     mem
);

  localparam int                    OFF       = offset_len(BANK_NUM);
  localparam logic [ADDR_WIDTH-1:0] OFF_MASK  = ADDR_WIDTH'(BANK_NUM - 1);
  localparam logic [OFF-1:0]        LAST_BEAT = OFF'(BANK_NUM - 1);

  refill_state_t         state;
  logic [ADDR_WIDTH-1:0] base;
  logic [OFF-1:0]        beat;
  logic                  way;

  // base has its offset bits cleared, so OR-ing the beat never carries into the tag/index.
  assign mem.mem_req_addr = base | ADDR_WIDTH'(beat);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state             <= IDLE;
      base              <= '0;
      beat              <= '0;
      way               <= 1'b0;
      busy_rd           <= 1'b0;
      wen_rd            <= 1'b0;
      finish_rd         <= 1'b0;
      addr_rd           <= '0;
      data_rd           <= '0;
      set_rd            <= 1'b0;
      mem.mem_req_valid <= 1'b0;
    end else begin
      wen_rd    <= 1'b0;
      finish_rd <= 1'b0;
      unique case (state)
        IDLE: begin
          if (miss_cache) begin
            base              <= addr_cache & ~OFF_MASK;
            way               <= set_cache;
            beat              <= '0;
            busy_rd           <= 1'b1;
            mem.mem_req_valid <= 1'b1;
            state             <= REQ;
          end
        end
        REQ: begin
          if (mem.mem_req_ready) begin
            mem.mem_req_valid <= 1'b0;
            state             <= WAIT;
          end
        end
        WAIT: begin
          if (mem.mem_resp_valid) begin
            wen_rd  <= 1'b1;
            addr_rd <= mem.mem_req_addr;
            data_rd <= mem.mem_resp_data;
            set_rd  <= way;
            if (beat != LAST_BEAT) begin
              beat              <= beat + 1'b1;
              mem.mem_req_valid <= 1'b1;
              state             <= REQ;
            end else begin
              state <= LAST;
            end
          end
        end
        LAST: begin
          // The final write strobe is on the outputs now; validate the line next cycle.
          finish_rd <= 1'b1;
          addr_rd   <= base;
          set_rd    <= way;
          state     <= DONE;
        end
        DONE: begin
          busy_rd <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tlb_refill_ctrl.sv
// tb/tb_tlb_refill_ctrl.sv - randomized refill bench checked against a line-level reference model
`timescale 1ns/1ps
module tb_tlb_refill_ctrl;

  localparam int AW = 64;
  localparam int DW = 64;
  localparam int BN = 4;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          miss_cache = 1'b0;
  logic [AW-1:0] addr_cache = '0;
  logic          set_cache = 1'b0;
  logic          busy_rd, wen_rd, set_rd, finish_rd;
  logic [AW-1:0] addr_rd;
  logic [DW-1:0] data_rd;

  always #5 clk = ~clk;

  tlb_refill_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) mem_if ();

  tlb_refill_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BANK_NUM(BN)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .miss_cache (miss_cache),
    .addr_cache (addr_cache),
    .set_cache  (set_cache),
    .busy_rd    (busy_rd),
    .addr_rd    (addr_rd),
    .data_rd    (data_rd),
    .wen_rd     (wen_rd),
    .set_rd     (set_rd),
    .finish_rd  (finish_rd),
    .mem        (mem_if)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Memory contents: a function of the word address only.
  int            stall_cycles = 0;
  int            resp_lat = 1;
  bit            stray_en = 1'b0;
  bit            hash_en = 1'b0;
  logic [DW-1:0] data_seed = '0;
  logic [AW-1:0] req_log[$];

  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    if (hash_en) return data_seed ^ (a * 64'h9E37_79B9_7F4A_7C15);
    return data_seed + DW'(a % BN);
  endfunction

  initial begin : mem_model
    int            stall_cnt;
    int            timer;
    bit            acc;
    bit            stray_done;
    logic [AW-1:0] acc_addr;
    logic [AW-1:0] pend_addr;
    stall_cnt = 0;
    timer = 0;
    stray_done = 1'b0;
    pend_addr = '0;
    mem_if.mem_req_ready  = 1'b0;
    mem_if.mem_resp_valid = 1'b0;
    mem_if.mem_resp_data  = '0;
    forever begin
      @(negedge clk);
      acc      = mem_if.mem_req_valid && mem_if.mem_req_ready;
      acc_addr = mem_if.mem_req_addr;
      if (!mem_if.mem_req_valid) stall_cnt = 0;
      else if (!mem_if.mem_req_ready) stall_cnt++;
      @(posedge clk);
      #1;
      mem_if.mem_resp_valid = 1'b0;
      if (acc) begin
        req_log.push_back(acc_addr);
        pend_addr  = acc_addr;
        timer      = resp_lat;
        stall_cnt  = 0;
        stray_done = 1'b0;
      end
      if (timer > 0) begin
        timer--;
        if (timer == 0) begin
          mem_if.mem_resp_valid = 1'b1;
          mem_if.mem_resp_data  = mem_word(pend_addr);
        end
      end else if (stray_en && !stray_done && mem_if.mem_req_valid && stall_cnt == 1) begin
        mem_if.mem_resp_valid = 1'b1;
        mem_if.mem_resp_data  = '1;
        stray_done = 1'b1;
      end
      mem_if.mem_req_ready = (stall_cnt >= stall_cycles);
    end
  end

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic          s;
  } wr_t;

  wr_t           wr_log[$];
  int            fin_cnt = 0, fin_cyc = 0, busy_cnt = 0, busy_first = -1;
  int            overlap_cnt = 0, fin_order_err = 0, stable_err = 0;
  logic [AW-1:0] fin_addr = '0;
  logic          fin_set = 1'b0;

  initial begin : monitor
    bit            prev_wen;
    bit            prev_stall;
    logic [AW-1:0] prev_addr;
    prev_wen = 1'b0;
    prev_stall = 1'b0;
    prev_addr = '0;
    forever begin
      @(negedge clk);
      if (wen_rd) wr_log.push_back('{addr_rd, data_rd, set_rd});
      if (finish_rd) begin
        fin_cnt++;
        fin_cyc  = cyc;
        fin_addr = addr_rd;
        fin_set  = set_rd;
        if (!prev_wen) fin_order_err++;
      end
      if (wen_rd && finish_rd) overlap_cnt++;
      if (busy_rd) begin
        if (busy_first < 0) busy_first = cyc;
        busy_cnt++;
      end
      if (prev_stall && !(mem_if.mem_req_valid && mem_if.mem_req_addr == prev_addr)) stable_err++;
      prev_stall = mem_if.mem_req_valid && !mem_if.mem_req_ready;
      prev_addr  = mem_if.mem_req_addr;
      prev_wen   = wen_rd;
    end
  end

  task automatic clear_mon();
    wr_log.delete();
    req_log.delete();
    fin_cnt = 0;
    busy_cnt = 0;
    busy_first = -1;
    overlap_cnt = 0;
    fin_order_err = 0;
    stable_err = 0;
  endtask

  task automatic wait_finish(input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(posedge clk);
      #1;
      if (fin_cnt > 0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Expected line behaviour derived from the miss alone: beats in order, fixed per-beat cost.
  task automatic verify_fill(input string tag, input logic [AW-1:0] addr, input logic way,
                             input int stall, input int lat, input int c0);
    logic [AW-1:0] base;
    logic [AW-1:0] wa;
    int            span;
    base = addr & ~AW'(BN - 1);
    span = BN * (stall + 1 + lat) + 2;
    check({tag, "/nreq"}, 64'(req_log.size()), 64'(BN));
    check({tag, "/nwr"}, 64'(wr_log.size()), 64'(BN));
    for (int i = 0; i < BN; i++) begin
      wa = base + AW'(i);
      if (i < req_log.size()) check({tag, "/req_addr"}, req_log[i], wa);
      if (i < wr_log.size()) begin
        check({tag, "/wr_addr"}, wr_log[i].a, wa);
        check({tag, "/wr_data"}, wr_log[i].d, mem_word(wa));
        check({tag, "/wr_set"}, 64'(wr_log[i].s), 64'(way));
      end
    end
    check({tag, "/fin_cnt"}, 64'(fin_cnt), 64'd1);
    check({tag, "/fin_cyc"}, 64'(fin_cyc), 64'(c0 + span));
    check({tag, "/fin_addr"}, fin_addr, base);
    check({tag, "/fin_set"}, 64'(fin_set), 64'(way));
    check({tag, "/busy_first"}, 64'(busy_first), 64'(c0 + 1));
    check({tag, "/busy_cnt"}, 64'(busy_cnt), 64'(span));
    check({tag, "/overlap"}, 64'(overlap_cnt), 64'd0);
    check({tag, "/fin_after_wen"}, 64'(fin_order_err), 64'd0);
    check({tag, "/req_stable"}, 64'(stable_err), 64'd0);
  endtask

  // Caller is 1ns after a rising edge with the block idle.
  task automatic run_fill(input string tag, input logic [AW-1:0] addr, input logic way,
                          input int stall, input int lat, input bit stray, input bit busy_miss);
    int c0;
    bit ok;
    stall_cycles = stall;
    resp_lat     = lat;
    stray_en     = stray;
    clear_mon();
    miss_cache = 1'b1;
    addr_cache = addr;
    set_cache  = way;
    c0 = cyc;
    @(posedge clk);
    #1;
    miss_cache = 1'b0;
    if (busy_miss) begin
      repeat (3) @(posedge clk);
      #1;
      miss_cache = 1'b1;
      addr_cache = 64'h9990;
      set_cache  = ~way;
      @(posedge clk);
      #1;
      miss_cache = 1'b0;
    end
    wait_finish(400, ok);
    check({tag, "/done"}, 64'(ok), 64'd1);
    verify_fill(tag, addr, way, stall, lat, c0);
  endtask

  initial begin : main
    bit            ok;
    logic [AW-1:0] ra;
    repeat (3) @(posedge clk);
    #1;
    check("rst/busy", 64'(busy_rd), 64'd0);
    check("rst/wen", 64'(wen_rd), 64'd0);
    check("rst/finish", 64'(finish_rd), 64'd0);
    check("rst/req_valid", 64'(mem_if.mem_req_valid), 64'd0);
    check("rst/addr_rd", addr_rd, 64'd0);
    check("rst/data_rd", data_rd, 64'd0);
    check("rst/set_rd", 64'(set_rd), 64'd0);
    check("rst/req_addr", mem_if.mem_req_addr, 64'd0);
    rstn = 1'b1;
    @(posedge clk);
    #1;

    hash_en   = 1'b0;
    data_seed = 64'hA0;
    run_fill("basic", 64'h1234, 1'b1, 0, 1, 1'b0, 1'b0);
    check("basic/first_data", wr_log.size() > 0 ? wr_log[0].d : '0, 64'hA0);
    check("basic/last_data", wr_log.size() == BN ? wr_log[BN-1].d : '0, 64'hA3);

    hash_en   = 1'b1;
    data_seed = {$urandom, $urandom};
    run_fill("backpressure", 64'h1234, 1'b0, 3, 1, 1'b0, 1'b0);
    run_fill("delay_stray", 64'h5678, 1'b1, 2, 5, 1'b1, 1'b0);
    run_fill("miss_busy", 64'h2000, 1'b1, 0, 2, 1'b0, 1'b1);
    // Back-to-back: this miss lands in the cycle right after finish_rd.
    run_fill("b2b", 64'h80, 1'b0, 0, 1, 1'b0, 1'b0);

    // Reset while waiting on beat 2; the in-flight response must be dropped.
    stall_cycles = 0;
    resp_lat = 3;
    stray_en = 1'b0;
    clear_mon();
    miss_cache = 1'b1;
    addr_cache = 64'h3300;
    set_cache = 1'b1;
    @(posedge clk);
    #1;
    miss_cache = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      #1;
      if (wr_log.size() >= 2) begin
        ok = 1'b1;
        break;
      end
    end
    check("midrst/two_writes", 64'(ok), 64'd1);
    @(posedge clk);
    #1;
    rstn = 1'b0;
    #1;
    check("midrst/busy", 64'(busy_rd), 64'd0);
    check("midrst/wen", 64'(wen_rd), 64'd0);
    check("midrst/req_valid", 64'(mem_if.mem_req_valid), 64'd0);
    check("midrst/addr_rd", addr_rd, 64'd0);
    check("midrst/req_addr", mem_if.mem_req_addr, 64'd0);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    check("midrst/no_more_writes", 64'(wr_log.size()), 64'd2);
    check("midrst/no_finish", 64'(fin_cnt), 64'd0);
    check("midrst/idle", 64'(busy_rd), 64'd0);
    run_fill("post_rst", 64'h40, 1'b1, 0, 1, 1'b0, 1'b0);

    for (int n = 0; n < 6; n++) begin
      ra = {$urandom, $urandom};
      data_seed = {$urandom, $urandom};
      run_fill("rand", ra, 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
               int'($urandom_range(1, 4)), 1'($urandom_range(0, 1)), 1'b0);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
